// File: rtl/risc16_pkg.sv
// Purpose: shared widths, reset PC and the fetch queue payload type for the
// risc16 front end.
package risc16_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  // One prefetched instruction tagged with the word address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: small synchronous FIFO holding prefetched {pc, instr} entries.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          retire the head entry
//   flush        discard all entries (overrides push/pop)
//   full, empty  occupancy flags
//   head         entry at the head of the queue
module fetch_fifo
  import risc16_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  // Entry storage; a push into a full queue only happens alongside a pop,
  // so the slot being overwritten is the one leaving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (!flush && push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (pop && !push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: instruction fetch front end. Owns the PC, reads the asynchronous
// instruction memory and queues {pc, instr} for decode; redirects flush the
// queue and reload the PC.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_addr       word address to instruction memory (straight from the PC register)
//   imem_data       instruction for imem_addr, same cycle
//   fetch_en        allow new fetches; 0 holds the PC while the queue drains
//   redirect_valid  one-cycle branch/jump redirect
//   redirect_pc     redirect target
//   if_valid        head entry valid for decode
//   if_ready        decode accepts the head this cycle
//   if_pc, if_instr head entry contents
module instr_fetch_unit
  import risc16_pkg::fetch_entry_t;
#(
  parameter int unsigned ADDR_W     = risc16_pkg::ADDR_W,
  parameter int unsigned INSTR_W    = risc16_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = risc16_pkg::RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_if_valid;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // A redirect hides the head so nothing fetched on the old path escapes.
  assign w_if_valid = !w_empty && !redirect_valid;
  assign w_pop      = w_if_valid && if_ready;
  // A full queue can still accept a fetch when the head leaves this cycle.
  assign w_push     = fetch_en && !redirect_valid && (!w_full || w_pop);

  assign w_push_entry.pc    = r_fetch_pc;
  assign w_push_entry.instr = imem_data;

  // Program counter: redirect wins, otherwise advance on every accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign imem_addr = r_fetch_pc;
  assign if_valid  = w_if_valid;
  assign if_pc     = w_head.pc;
  assign if_instr  = w_head.instr;

endmodule
